// File: rtl/axi2per_txn_tracker_pkg.sv
// Shared types and width helpers for the AXI-to-peripheral transaction tracker.
package axi2per_tracker_pkg;

    localparam int unsigned ID_WIDTH_DEFAULT = 6;

    // AXI transaction ID at the bridge's default ID width
    typedef logic [ID_WIDTH_DEFAULT-1:0] id_t;

    // Width needed to hold an occupancy count from 0 up to depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a queue slot index; at least one bit so a depth-1 queue still has a pointer
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi2per_id_fifo.sv
// In-order ID queue: synchronous FIFO with registered head, occupancy count and
// modulo-DEPTH pointers so non-power-of-2 depths wrap correctly.
module axi2per_id_fifo
    import axi2per_tracker_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_WIDTH = cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [WIDTH-1:0]     head_o
);

    localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 push_ok;
    logic                 pop_ok;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard push/pop against full/empty and compute next pointers and occupancy
    always_comb begin
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    // Storage, pointers and count; reset clears storage so the head reads 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi2per_txn_tracker.sv
// Responder-side outstanding-transaction tracker: queues accepted AW/AR IDs,
// backpressures at MAX_OUTSTANDING, gates B/R responses and stamps them with
// the queued ID, reports busy and flags spurious responses.
module axi2per_txn_tracker
    import axi2per_tracker_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = 6,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned CNT_WIDTH      = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    input  logic [ID_WIDTH-1:0]  aw_id_i,
    input  logic                 aw_ready_i,
    output logic                 aw_ready_o,
    input  logic                 b_valid_i,
    input  logic                 b_ready_i,
    output logic                 b_valid_o,
    output logic [ID_WIDTH-1:0]  b_id_o,
    input  logic                 ar_valid_i,
    input  logic [ID_WIDTH-1:0]  ar_id_i,
    input  logic                 ar_ready_i,
    output logic                 ar_ready_o,
    input  logic                 r_valid_i,
    input  logic                 r_last_i,
    input  logic                 r_ready_i,
    output logic                 r_valid_o,
    output logic [ID_WIDTH-1:0]  r_id_o,
    output logic [CNT_WIDTH-1:0] aw_count_o,
    output logic [CNT_WIDTH-1:0] ar_count_o,
    output logic                 busy_o,
    output logic                 err_o
);

    logic aw_full, aw_empty;
    logic ar_full, ar_empty;
    logic aw_push, b_pop;
    logic ar_push, r_pop;
    logic err_q, err_d;

    // Handshake gating: ready is blocked while full (no pass-through on a
    // same-cycle pop), responses are blocked while no ID is queued (no bypass)
    always_comb begin
        aw_ready_o = aw_ready_i & ~aw_full;
        ar_ready_o = ar_ready_i & ~ar_full;
        b_valid_o  = b_valid_i & ~aw_empty;
        r_valid_o  = r_valid_i & ~ar_empty;
        aw_push    = aw_valid_i & aw_ready_o;
        ar_push    = ar_valid_i & ar_ready_o;
        b_pop      = b_valid_o & b_ready_i;
        r_pop      = r_valid_o & r_ready_i & r_last_i;
        busy_o     = (aw_count_o != '0) | (ar_count_o != '0);
        err_d      = err_q | (b_valid_i & aw_empty) | (r_valid_i & ar_empty);
    end

    axi2per_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_wr_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (aw_push),
        .data_i  (aw_id_i),
        .pop_i   (b_pop),
        .full_o  (aw_full),
        .empty_o (aw_empty),
        .count_o (aw_count_o),
        .head_o  (b_id_o)
    );

    axi2per_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rd_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ar_push),
        .data_i  (ar_id_i),
        .pop_i   (r_pop),
        .full_o  (ar_full),
        .empty_o (ar_empty),
        .count_o (ar_count_o),
        .head_o  (r_id_o)
    );

    // Sticky spurious-response flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_axi2per_txn_tracker.sv
// Directed, table-driven bench for axi2per_txn_tracker (depth 8) plus a
// depth-5 instance for non-power-of-2 pointer wrap.
module tb_axi2per_txn_tracker;
    import axi2per_tracker_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       aw_valid, aw_ready, b_valid, b_ready;
    logic       ar_valid, ar_ready, r_valid, r_last, r_ready;
    id_t        aw_id, ar_id;

    logic       aw_ready_o, b_valid_o, ar_ready_o, r_valid_o, busy_o, err_o;
    id_t        b_id_o, r_id_o;
    logic [3:0] aw_count_o, ar_count_o;

    logic       aw_ready5, b_valid5, ar_ready5, r_valid5, busy5, err5;
    id_t        b_id5, r_id5;
    logic [2:0] aw_count5, ar_count5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi2per_txn_tracker #(.ID_WIDTH(6), .MAX_OUTSTANDING(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_ready_i(aw_ready), .aw_ready_o(aw_ready_o),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_valid_o(b_valid_o), .b_id_o(b_id_o),
        .ar_valid_i(ar_valid), .ar_id_i(ar_id), .ar_ready_i(ar_ready), .ar_ready_o(ar_ready_o),
        .r_valid_i(r_valid), .r_last_i(r_last), .r_ready_i(r_ready), .r_valid_o(r_valid_o), .r_id_o(r_id_o),
        .aw_count_o(aw_count_o), .ar_count_o(ar_count_o), .busy_o(busy_o), .err_o(err_o)
    );

    axi2per_txn_tracker #(.ID_WIDTH(6), .MAX_OUTSTANDING(5)) dut5 (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_ready_i(aw_ready), .aw_ready_o(aw_ready5),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_valid_o(b_valid5), .b_id_o(b_id5),
        .ar_valid_i(ar_valid), .ar_id_i(ar_id), .ar_ready_i(ar_ready), .ar_ready_o(ar_ready5),
        .r_valid_i(r_valid), .r_last_i(r_last), .r_ready_i(r_ready), .r_valid_o(r_valid5), .r_id_o(r_id5),
        .aw_count_o(aw_count5), .ar_count_o(ar_count5), .busy_o(busy5), .err_o(err5)
    );

    typedef struct {
        logic awv; logic [5:0] awid; logic awr; logic bv; logic br;
        logic arv; logic [5:0] arid; logic arr; logic rv; logic rl; logic rr;
        logic cb; logic cr;
        logic e_awr; logic e_bv; logic [5:0] e_bid; logic e_arr; logic e_rv; logic [5:0] e_rid;
        logic [3:0] e_awc; logic [3:0] e_arc; logic e_busy; logic e_err;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        aw_valid = 1'b0; aw_id = '0; aw_ready = 1'b1;
        b_valid  = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; ar_id = '0; ar_ready = 1'b1;
        r_valid  = 1'b0; r_last = 1'b0; r_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watchdog: the bench never waits on DUT events, but guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [25:0] act, exp;

        //       awv awid  awr bv br arv arid  arr rv rl rr cb cr  awr bv bid   arr rv rid   awc arc busy err
        tbl[0]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 1, 1,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[1]  = '{1, 6'h05, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 1, 1,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[2]  = '{0, 6'h00, 1, 1, 1, 0, 6'h00, 1, 0, 0, 0, 1, 1,  1, 1, 6'h05, 1, 0, 6'h00, 1, 0, 1, 0};
        tbl[3]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 1,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[4]  = '{0, 6'h00, 1, 0, 0, 1, 6'h2A, 1, 0, 0, 0, 0, 1,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[5]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1, 0, 1, 0, 1,  1, 0, 6'h00, 1, 1, 6'h2A, 0, 1, 1, 0};
        tbl[6]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1, 0, 1, 0, 1,  1, 0, 6'h00, 1, 1, 6'h2A, 0, 1, 1, 0};
        tbl[7]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1, 1, 0, 0, 1,  1, 0, 6'h00, 1, 1, 6'h2A, 0, 1, 1, 0};
        tbl[8]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1, 1, 1, 0, 1,  1, 0, 6'h00, 1, 1, 6'h2A, 0, 1, 1, 0};
        tbl[9]  = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[10] = '{1, 6'h31, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[11] = '{1, 6'h32, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 0, 6'h31, 1, 0, 6'h00, 1, 0, 1, 0};
        tbl[12] = '{1, 6'h33, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 0, 6'h31, 1, 0, 6'h00, 2, 0, 1, 0};
        tbl[13] = '{1, 6'h34, 1, 1, 1, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 1, 6'h31, 1, 0, 6'h00, 3, 0, 1, 0};
        tbl[14] = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 0, 6'h32, 1, 0, 6'h00, 3, 0, 1, 0};
        tbl[15] = '{0, 6'h00, 1, 1, 1, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 1, 6'h32, 1, 0, 6'h00, 3, 0, 1, 0};
        tbl[16] = '{0, 6'h00, 1, 1, 1, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 1, 6'h33, 1, 0, 6'h00, 2, 0, 1, 0};
        tbl[17] = '{0, 6'h00, 1, 1, 1, 0, 6'h00, 1, 0, 0, 0, 1, 0,  1, 1, 6'h34, 1, 0, 6'h00, 1, 0, 1, 0};
        tbl[18] = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[19] = '{0, 6'h00, 1, 1, 1, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 0};
        tbl[20] = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 1};
        tbl[21] = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 1, 1, 1, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 1};
        tbl[22] = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 1};
        tbl[23] = '{1, 6'h3F, 0, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  0, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 1};
        tbl[24] = '{0, 6'h00, 1, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0, 0,  1, 0, 6'h00, 1, 0, 6'h00, 0, 0, 0, 1};

        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: single write, read burst, simultaneous push/pop, spurious responses
        for (int i = 0; i < 25; i++) begin
            aw_valid = tbl[i].awv; aw_id = tbl[i].awid; aw_ready = tbl[i].awr;
            b_valid  = tbl[i].bv;  b_ready = tbl[i].br;
            ar_valid = tbl[i].arv; ar_id = tbl[i].arid; ar_ready = tbl[i].arr;
            r_valid  = tbl[i].rv;  r_last = tbl[i].rl; r_ready = tbl[i].rr;
            #1;
            act = {aw_ready_o, b_valid_o, (tbl[i].cb ? b_id_o : 6'h00), ar_ready_o, r_valid_o,
                   (tbl[i].cr ? r_id_o : 6'h00), aw_count_o, ar_count_o, busy_o, err_o};
            exp = {tbl[i].e_awr, tbl[i].e_bv, tbl[i].e_bid, tbl[i].e_arr, tbl[i].e_rv,
                   tbl[i].e_rid, tbl[i].e_awc, tbl[i].e_arc, tbl[i].e_busy, tbl[i].e_err};
            chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
            step();
        end
        idle();

        // Fill to 8, stall the 9th AW, free one slot, then drain in order
        for (int i = 0; i < 8; i++) begin
            aw_valid = 1'b1; aw_id = 6'(i);
            #1 chk($sformatf("fill_ready%0d", i), 32'(aw_ready_o), 32'd1);
            step();
        end
        aw_valid = 1'b1; aw_id = 6'h08;
        #1 chk("full_ready", 32'(aw_ready_o), 32'd0);
        chk("full_count", 32'(aw_count_o), 32'd8);
        step();
        #1 chk("stall_count", 32'(aw_count_o), 32'd8);
        b_valid = 1'b1; b_ready = 1'b1;
        #1 chk("full_pop_ready", 32'(aw_ready_o), 32'd0);
        chk("full_pop_id", 32'(b_id_o), 32'h00);
        step();
        b_valid = 1'b0; b_ready = 1'b0;
        #1 chk("freed_ready", 32'(aw_ready_o), 32'd1);
        chk("freed_count", 32'(aw_count_o), 32'd7);
        step();
        aw_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            b_valid = 1'b1; b_ready = 1'b1;
            #1 chk($sformatf("drain_id%0d", k), 32'(b_id_o), 32'(k));
            step();
        end
        idle();
        #1 chk("drain_count", 32'(aw_count_o), 32'd0);

        // Depth-5 instance: keep 3 outstanding and push/pop 12 times across the wrap
        rst = 1'b1;
        #1 rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            aw_valid = 1'b1; aw_id = 6'(8'h10 + i);
            step();
        end
        for (int k = 0; k < 12; k++) begin
            aw_valid = 1'b1; aw_id = 6'(8'h13 + k);
            b_valid = 1'b1; b_ready = 1'b1;
            #1 chk($sformatf("wrap5_id%0d", k), 32'(b_id5), 32'(8'h10 + k));
            chk($sformatf("wrap5_cnt%0d", k), 32'(aw_count5), 32'd3);
            step();
        end
        aw_valid = 1'b0;
        for (int k = 12; k < 15; k++) begin
            #1 chk($sformatf("wrap5_tail%0d", k), 32'(b_id5), 32'(8'h10 + k));
            step();
        end
        idle();
        #1 chk("wrap5_empty", 32'({busy5, aw_count5}), 32'd0);

        // Reset mid-operation: 3 writes and 2 reads outstanding, async reset pulse
        step();
        for (int i = 0; i < 3; i++) begin
            aw_valid = 1'b1; aw_id = 6'(i + 1);
            ar_valid = (i < 2); ar_id = 6'(i + 4);
            step();
        end
        idle();
        #1 chk("pre_rst_counts", 32'({aw_count_o, ar_count_o, busy_o}), 32'({4'd3, 4'd2, 1'b1}));
        #1 rst = 1'b1;
        #1 chk("rst_async", 32'({aw_count_o, ar_count_o, busy_o, err_o}), 32'd0);
        chk("rst_ids", 32'({b_id_o, r_id_o, b_valid_o}), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        aw_valid = 1'b1; aw_id = 6'h11;
        step();
        idle();
        #1 chk("post_rst_head", 32'(b_id_o), 32'h11);
        chk("post_rst_count", 32'(aw_count_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
